sar_search: RTL and testbench
=============================

# sar_search

Successive-approximation search engine: the driving end of the magnitude comparator interface. It presents a trial value on `guess` to an external combinational comparator, where `guess` is the comparator's B and an unknown target is its A. It reads back the gt/eq/lt answer and binary-searches the target one bit per cycle, MSB first. It is used wherever a value is only observable through a comparator, for example threshold discovery or ADC-style conversion.

## Interface
- `WIDTH`, default 4: width of target, guess and result.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: request a search; honoured only in IDLE.
- `guess` output, WIDTH: trial value driven to the comparator's B input.
- `gt` input, 1: comparator says target > guess.
- `eq` input, 1: comparator says target == guess.
- `lt` input, 1: comparator says target < guess.
- `busy` output, 1: high in COMPARE and DONE.
- `done` output, 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output, WIDTH: registered search result, held until the next start.
- `err` output, 1: sticky flag for a protocol violation; cleared by the next accepted start.

## Operation
- States: IDLE, COMPARE, DONE. Encoding lives in the package.
- Internal registers: `acc` (WIDTH) and `idx` (log2 WIDTH, minimum 1 bit).
- IDLE:
  - `guess`=0.
  - On `start`: `acc`<=0, `idx`<=WIDTH-1, `err`<=0, go to COMPARE.
- COMPARE:
  - `guess` = `acc` | (1<<`idx`), combinational from registers.
  - gt/eq/lt are sampled at the clock edge that ends the cycle.
  - If gt|eq: `acc[idx]`<=1. Otherwise the bit stays 0.
  - If `idx`==0: go to DONE. Otherwise `idx`<=`idx`-1.
- Flag check: if gt/eq/lt is not exactly one-hot in a COMPARE cycle, `err`<=1. The bit decision still uses gt|eq.
- DONE:
  - `result`<=`acc` is loaded on entry.
  - `done`=1 for this one cycle, `guess`=0.
  - Return to IDLE.
- `start` while `busy` is ignored. That includes the DONE cycle.
- Arithmetic is unsigned only. No carry or overflow is possible: `guess` never exceeds 2^WIDTH-1.
- Reset:
  - Asserting `rst` mid-search aborts it immediately.
  - State returns to IDLE; `acc`, `idx` and `result` go to 0; `done`, `busy` and `err` go to 0.
- Reset values of all outputs: `guess`=0, `done`=0, `busy`=0, `result`=0, `err`=0.

## Timing
- Let the edge that accepts `start` be edge 0.
- Cycles 1..WIDTH are COMPARE. `guess` for bit k (MSB=WIDTH-1) is stable throughout cycle WIDTH-k.
- `done` is high in cycle WIDTH+1. `result` is updated at the same edge that raises `done`.
- Minimum spacing between starts is WIDTH+2 cycles, so a new `start` is accepted in cycle WIDTH+2 at the earliest.
- The comparator path guess→gt/eq/lt must settle within one cycle. No pipelining of that path is supported.

## Configuration
- `SAR_EARLY_EXIT_EN`, defined:
  - In COMPARE, `eq`=1 loads `acc`<=`guess` and jumps straight to DONE.
  - Latency becomes (MSB-first index of the lowest set bit of the target)+1 compare cycles, with done in the following cycle.
  - A target of 0 still takes WIDTH compares.
- Undefined:
  - `eq` only contributes through gt|eq.
  - Latency is always WIDTH compares plus the DONE cycle.
- `err` checking is identical in both builds.

## Structure
- `sar_pkg` holds:
  - State encoding localparams: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2.
  - The default WIDTH.
  - A clog2 helper function for the `idx` width.
- One sub-module is natural: `sar_bit_mask`, a combinational `idx`→one-hot WIDTH-bit decoder used to build `guess` and the `acc` bit set.
- The comparator itself is external. The bench instantiates the team's 4-bit comparator as its model.

## Test plan
- WIDTH=4, target 11, no macro: `guess` sequence 8,12,10,11; `acc` bits 1,0,1,1; `done` in cycle 5; `result`=11; `err`=0.
- Target 0: guesses 8,4,2,1, all answered lt → `result`=0 at cycle 5. Target 15: guesses 8,12,14,15 → `result`=15.
- `SAR_EARLY_EXIT_EN`, target 8: single guess 8 answered eq → `done` in cycle 2, `result`=8. Target 0 → still `done` in cycle 5.
- Bench forces gt=lt=1 during the second compare: `err`=1 after that edge and stays high through DONE and IDLE. The next `start` clears it.
- `start` pulsed in cycles 2 and 5 of a running search: both ignored, no restart. `result` reflects the first search only.
- `rst` asserted asynchronously in cycle 3 of a search for target 11: `busy`, `guess`, `done` and `result` are 0 immediately. After release, a `start` with target 6 yields `result`=6 normally.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine:
// state encoding, default width and the index-width helper.
package sar_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } sar_state_e;

    // Bits needed to index WIDTH positions; never less than one bit.
    function automatic int idxWidth(input int w);
        int r;
        r = 1;
        while ((1 << r) < w) r++;
        return r;
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator-side bus of the search engine: trial value out, gt/eq/lt answer back,
// plus the start/busy/done/result/err handshake.
interface sar_search_if
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] guess;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, gt, eq, lt,
        output guess, busy, done, result, err
    );

    modport slave (
        output start, gt, eq, lt,
        input  guess, busy, done, result, err
    );

endinterface

// File: rtl/sar_bit_mask.sv
// Decodes the current bit index into a one-hot mask; used both for the trial
// value and for setting the accepted bit in the accumulator.
module sar_bit_mask #(
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  logic [IW-1:0]    idx_i,
    output logic [WIDTH-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_i == IW'(i)) mask_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search, one bit per cycle MSB first, against an external comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    sar_search_if.master bus
);

    localparam int IW = idxWidth(WIDTH);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] bitMask;
    logic [WIDTH-1:0] trialGuess;
    logic             flagsOk;

    sar_bit_mask #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_mask (
        .idx_i  (idx_q),
        .mask_o (bitMask)
    );

    assign trialGuess = acc_q | bitMask;
    // Exactly one of three: odd parity rules out 0 and 2, the AND rules out 3.
    assign flagsOk    = (bus.gt ^ bus.eq ^ bus.lt) & ~(bus.gt & bus.eq & bus.lt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    idx_d   = IW'(WIDTH - 1);
                    err_d   = 1'b0;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (!flagsOk) err_d = 1'b1;
                if (bus.gt | bus.eq) acc_d = trialGuess;
`ifdef SAR_EARLY_EXIT_EN
                if (bus.eq) begin
                    acc_d   = trialGuess;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
`else
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
`endif
                // Result is captured on the edge entering DONE so it is valid alongside done.
                if (state_d == DONE) result_d = acc_d;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.guess  = (state_q == COMPARE) ? trialGuess : '0;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search at WIDTH=4 with a behavioural comparator on the guess bus;
// expected guess sequences follow the build's SAR_EARLY_EXIT_EN setting.
module tb_sar_search;

   logic       clk;
   logic       rst;
   logic [3:0] targetVal;
   logic       forceBad;
   int         checkCount;
   int         passCount;

   sar_search_if #(.WIDTH(4)) bus ();

   sar_search #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Comparator model: target is A, guess is B; forceBad injects an illegal gt+lt answer.
   assign bus.gt = forceBad ? 1'b1 : (targetVal >  bus.guess);
   assign bus.eq = forceBad ? 1'b0 : (targetVal == bus.guess);
   assign bus.lt = forceBad ? 1'b1 : (targetVal <  bus.guess);

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SAR_EARLY_EXIT_EN
   localparam int         T8_CMPS  = 1;
   localparam logic [15:0] T8_SEQ  = 16'h8000;
   localparam int         T6_CMPS  = 3;
   localparam logic [15:0] T6_SEQ  = 16'h8460;
`else
   localparam int         T8_CMPS  = 4;
   localparam logic [15:0] T8_SEQ  = 16'h8CA9;
   localparam int         T6_CMPS  = 4;
   localparam logic [15:0] T6_SEQ  = 16'h8467;
`endif

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Runs one full search and checks each guess (MSB nibble of guessSeq first), done timing and result.
   task automatic applyStimulus(input string tag, input logic [3:0] tgt, input int nCmp,
                                input logic [15:0] guessSeq, input logic [3:0] expResult);
      targetVal = tgt;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= nCmp; c++) begin
         @(negedge clk);
         checkOutput({tag, "_guess"}, 32'(bus.guess), 32'(guessSeq[15 - 4*(c-1) -: 4]));
         checkOutput({tag, "_busy"},  32'(bus.busy), 32'd1);
         checkOutput({tag, "_nodone"}, 32'(bus.done), 32'd0);
         if (c == 1) checkOutput({tag, "_errclr"}, 32'(bus.err), 32'd0);
      end
      @(negedge clk);
      checkOutput({tag, "_done"},   32'(bus.done),   32'd1);
      checkOutput({tag, "_result"}, 32'(bus.result), 32'(expResult));
      checkOutput({tag, "_dguess"}, 32'(bus.guess),  32'd0);
      @(negedge clk);
      checkOutput({tag, "_idle"},   32'(bus.busy),   32'd0);
      checkOutput({tag, "_pulse"},  32'(bus.done),   32'd0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst        = 1'b1;
      forceBad   = 1'b0;
      targetVal  = 4'd0;
      bus.start  = 1'b0;

      #12;
      checkOutput("rst_guess",  32'(bus.guess),  32'd0);
      checkOutput("rst_done",   32'(bus.done),   32'd0);
      checkOutput("rst_busy",   32'(bus.busy),   32'd0);
      checkOutput("rst_result", 32'(bus.result), 32'd0);
      checkOutput("rst_err",    32'(bus.err),    32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("t11", 4'd11, 4, 16'h8CAB, 4'd11);
      applyStimulus("t0",  4'd0,  4, 16'h8421, 4'd0);
      applyStimulus("t15", 4'd15, 4, 16'h8CEF, 4'd15);
      applyStimulus("t8",  4'd8,  T8_CMPS, T8_SEQ, 4'd8);

      // Illegal gt+lt answer in the second compare forces bit 2 set and raises err.
      targetVal = 4'd11;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("err_g1", 32'(bus.guess), 32'd8);
      @(negedge clk);
      checkOutput("err_g2", 32'(bus.guess), 32'd12);
      checkOutput("err_pre", 32'(bus.err), 32'd0);
      forceBad = 1'b1;
      @(posedge clk);
      #1 forceBad = 1'b0;
      checkOutput("err_set", 32'(bus.err), 32'd1);
      @(negedge clk);
      checkOutput("err_g3", 32'(bus.guess), 32'd14);
      @(negedge clk);
      checkOutput("err_g4", 32'(bus.guess), 32'd13);
      @(negedge clk);
      checkOutput("err_done",   32'(bus.done),   32'd1);
      checkOutput("err_result", 32'(bus.result), 32'd12);
      checkOutput("err_indone", 32'(bus.err),    32'd1);
      @(negedge clk);
      checkOutput("err_inidle", 32'(bus.err),    32'd1);
      applyStimulus("t15b", 4'd15, 4, 16'h8CEF, 4'd15);

      // Start pulses during compare cycle 2 and the DONE cycle are ignored.
      targetVal = 4'd11;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("ign_g1", 32'(bus.guess), 32'd8);
      @(negedge clk);
      checkOutput("ign_g2", 32'(bus.guess), 32'd12);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("ign_g3", 32'(bus.guess), 32'd10);
      @(negedge clk);
      checkOutput("ign_g4", 32'(bus.guess), 32'd11);
      @(negedge clk);
      checkOutput("ign_done",   32'(bus.done),   32'd1);
      checkOutput("ign_result", 32'(bus.result), 32'd11);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checkOutput("ign_idle",   32'(bus.busy),   32'd0);
      checkOutput("ign_noguess", 32'(bus.guess), 32'd0);
      checkOutput("ign_hold",   32'(bus.result), 32'd11);

      // Asynchronous reset in compare cycle 3 aborts the search at once.
      targetVal = 4'd11;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("ar_pre", 32'(bus.guess), 32'd10);
      #2 rst = 1'b1;
      #1;
      checkOutput("ar_busy",   32'(bus.busy),   32'd0);
      checkOutput("ar_guess",  32'(bus.guess),  32'd0);
      checkOutput("ar_done",   32'(bus.done),   32'd0);
      checkOutput("ar_result", 32'(bus.result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("t6", 4'd6, T6_CMPS, T6_SEQ, 4'd6);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Absolute time limit so a stuck run still reports.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
      $fatal(1, "[TB] timeout");
   end

endmodule
